// File: rtl/ival_load_arbiter.sv
// Purpose : round-robin owner of the shared ival load bus; drives ival/gnt and a one-hot ld strobe.
// Latency : gnt/ival one edge after a request is seen in IDLE; ld HOLD edges later; HOLD+3 cycles per transfer.
// Backpres: requesters hold req (level) until their ld; a dropped req during SETUP aborts the transfer.
//
// Ports
//   sysclk   : system clock, rising edge
//   preset   : asynchronous reset, active-low
//   req      : per-requester load request, level
//   req_data : requester i data in bits [i*DW +: DW], sampled only at grant
//   gnt      : one-hot grant, registered
//   ival     : shared load bus, registered, changes only at a grant
//   ld       : one-hot one-cycle load strobe to the granted target
//   busy     : high whenever the arbiter is not idle

module ival_load_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int HOLD = 2
) (
    input  logic                 sysclk,
    input  logic                 preset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [DW-1:0]        ival,
    output logic [NREQ-1:0]      ld,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PW-1:0]   rr_ptr;     // first index examined by the next search
    logic [PW-1:0]   win_idx;    // index of the current owner
    logic [3:0]      cnt;        // remaining setup cycles before the strobe
    logic [PW-1:0]   rr_sel;
    logic            rr_found;
    logic            own_req;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        onehot = NREQ'(1) << idx;
    endfunction

    // The owner's request is picked out through gnt, which is one-hot on the
    // owner for the whole of SETUP; this avoids indexing req with a value
    // that could, in principle, exceed NREQ-1.
    assign own_req = |(req & gnt);

    // Round-robin search: start at rr_ptr, wrap NREQ-1 -> 0, first hit wins.
    always_comb begin
        int cand;
        cand     = 0;
        rr_found = 1'b0;
        rr_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_sel   = PW'(cand);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge preset) begin
        if (!preset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rr_found) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Abort has priority over reaching the end of the hold.
                if (!own_req) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from registered state
    // ------------------------------------------------------------------
    // ld is taken from gnt while in LOAD, so ld != 0 always implies gnt == ld.
    always_comb begin
        ld   = '0;
        busy = 1'b0;
        if (state == ST_LOAD) begin
            ld = gnt;
        end
        if (state != ST_IDLE) begin
            busy = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered bus drive, grant, hold counter and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge preset) begin
        if (!preset) begin
            gnt     <= '0;
            ival    <= '0;
            win_idx <= '0;
            cnt     <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        gnt     <= onehot(rr_sel);
                        ival    <= req_data[int'(rr_sel)*DW +: DW];
                        win_idx <= rr_sel;
                        cnt     <= 4'(HOLD - 1);
                    end
                end
                ST_SETUP: begin
                    // On abort the pointer stays put so the same requester
                    // keeps its turn; ival deliberately keeps the granted data.
                    if (!own_req) begin
                        gnt <= '0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_LOAD: begin
                    gnt <= '0;
                    if (win_idx == PW'(NREQ - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= win_idx + PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ival_load_arbiter.sv
// Bench for ival_load_arbiter: two instances (HOLD=2 and HOLD=1) share one
// stimulus stream; a transaction-level model (owner / cycles since grant /
// dead-cycle count / pointer) predicts every output of both each cycle.

module tb_ival_load_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;

    logic                sysclk = 1'b0;
    logic                preset;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  req_data;

    logic [NREQ-1:0]     gnt_o  [2];
    logic [NREQ-1:0]     ld_o   [2];
    logic [DW-1:0]       ival_o [2];
    logic                busy_o [2];

    always #5 sysclk = ~sysclk;

    ival_load_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD(2)) dut0 (
        .sysclk   (sysclk),
        .preset   (preset),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt_o[0]),
        .ival     (ival_o[0]),
        .ld       (ld_o[0]),
        .busy     (busy_o[0])
    );

    ival_load_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD(1)) dut1 (
        .sysclk   (sysclk),
        .preset   (preset),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt_o[1]),
        .ival     (ival_o[1]),
        .ld       (ld_o[1]),
        .busy     (busy_o[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_hold  [2];
    int          m_owner [2];   // -1 when nobody owns the bus
    int          m_age   [2];   // edges since the grant
    int          m_cool  [2];   // dead edges left before a grant is allowed
    int          m_ptr   [2];
    logic [DW-1:0] m_ival [2];

    task automatic m_reset();
        for (int u = 0; u < 2; u++) begin
            m_owner[u] = -1;
            m_age[u]   = 0;
            m_cool[u]  = 0;
            m_ptr[u]   = 0;
            m_ival[u]  = '0;
        end
    endtask

    task automatic m_step(input int u, input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d);
        int w;
        if (m_owner[u] >= 0) begin
            if (m_age[u] == m_hold[u]) begin
                m_ptr[u]   = (m_owner[u] + 1) % NREQ;
                m_owner[u] = -1;
                m_cool[u]  = 1;
            end else if (!r[m_owner[u]]) begin
                m_owner[u] = -1;
            end else begin
                m_age[u]++;
            end
        end else if (m_cool[u] > 0) begin
            m_cool[u]--;
        end else if (r != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                w = (m_ptr[u] + k) % NREQ;
                if (m_owner[u] < 0 && r[w]) begin
                    m_owner[u] = w;
                    m_age[u]   = 0;
                    m_ival[u]  = d[w*DW +: DW];
                end
            end
        end
    endtask

    task automatic check_all();
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_ld;
        logic            e_busy;
        for (int u = 0; u < 2; u++) begin
            e_gnt  = '0;
            e_ld   = '0;
            if (m_owner[u] >= 0) begin
                e_gnt[m_owner[u]] = 1'b1;
                if (m_age[u] == m_hold[u]) begin
                    e_ld = e_gnt;
                end
            end
            e_busy = (m_owner[u] >= 0) || (m_cool[u] > 0);
            check_eq($sformatf("gnt%0d", u),  64'(gnt_o[u]),  64'(e_gnt));
            check_eq($sformatf("ld%0d", u),   64'(ld_o[u]),   64'(e_ld));
            check_eq($sformatf("ival%0d", u), 64'(ival_o[u]), 64'(m_ival[u]));
            check_eq($sformatf("busy%0d", u), 64'(busy_o[u]), 64'(e_busy));
        end
    endtask

    // One clock: drive inputs, model follows the edge, compare on the falling edge.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d);
        req      = r;
        req_data = d;
        @(posedge sysclk);
        m_step(0, r, d);
        m_step(1, r, d);
        @(negedge sysclk);
        check_all();
    endtask

    // Called just after a falling edge: reset pulse entirely between edges.
    task automatic pulse_reset();
        #2 preset = 1'b0;
        #1 m_reset();
        check_all();
        #1 preset = 1'b1;
    endtask

    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0]    r;
    logic [NREQ-1:0]    ld_seq [$];
    int                 ld_cyc [$];
    int                 zrun;
    int                 zmax;

    initial begin
        m_hold[0] = 2;
        m_hold[1] = 1;
        m_reset();
        preset   = 1'b0;
        req      = '0;
        req_data = '0;
        #2 check_all();
        @(negedge sysclk);
        preset = 1'b1;

        // ---- single request ----
        d = '0;
        d[0 +: DW] = 32'hDEADBEEF;
        step(3'b001, d);
        check_eq("t2_gnt", 64'(gnt_o[0]), 64'h1);
        check_eq("t2_ival", 64'(ival_o[0]), 64'hDEADBEEF);
        step(3'b001, d);
        check_eq("t2_ld_early", 64'(ld_o[0]), 64'h0);
        step(3'b001, d);
        check_eq("t2_ld", 64'(ld_o[0]), 64'h1);
        step(3'b000, d);
        check_eq("t2_ld_off", 64'(ld_o[0]), 64'h0);
        check_eq("t2_busy_rel", 64'(busy_o[0]), 64'h1);
        step(3'b000, d);
        check_eq("t2_busy_idle", 64'(busy_o[0]), 64'h0);

        // ---- reset mid-transfer (requester 1 in LOAD, pointer at 1) ----
        d[DW +: DW] = 32'hA5A50001;
        step(3'b010, d);
        step(3'b010, d);
        step(3'b010, d);
        check_eq("t1_ld_pre", 64'(ld_o[0]), 64'h2);
        #2 preset = 1'b0;
        #1 m_reset();
        check_eq("t1_rst_gnt", 64'(gnt_o[0]), 64'h0);
        check_eq("t1_rst_ld", 64'(ld_o[0]), 64'h0);
        check_eq("t1_rst_ival", 64'(ival_o[0]), 64'h0);
        check_eq("t1_rst_busy", 64'(busy_o[0]), 64'h0);
        check_all();
        #1 preset = 1'b1;
        step(3'b011, d);
        check_eq("t1_first", 64'(gnt_o[0]), 64'h1);
        for (int i = 0; i < 6; i++) step(3'b011, d);

        // ---- all requesting ----
        pulse_reset();
        zrun = 0;
        zmax = 0;
        for (int c = 1; c <= 22; c++) begin
            step(3'b111, d);
            if (ld_o[0] != '0) begin
                ld_seq.push_back(ld_o[0]);
                ld_cyc.push_back(c);
            end
            if (gnt_o[0] == '0) begin
                zrun++;
                if (zrun > zmax) zmax = zrun;
            end else begin
                zrun = 0;
            end
        end
        check_eq("t3_npulse", 64'(ld_seq.size()), 64'd4);
        if (ld_seq.size() >= 4) begin
            check_eq("t3_seq0", 64'(ld_seq[0]), 64'h1);
            check_eq("t3_seq1", 64'(ld_seq[1]), 64'h2);
            check_eq("t3_seq2", 64'(ld_seq[2]), 64'h4);
            check_eq("t3_seq3", 64'(ld_seq[3]), 64'h1);
            check_eq("t3_first_at", 64'(ld_cyc[0]), 64'd3);
            for (int i = 1; i < 4; i++) begin
                check_eq($sformatf("t3_period%0d", i), 64'(ld_cyc[i] - ld_cyc[i-1]), 64'd5);
            end
        end
        check_eq("t3_gap", 64'(zmax), 64'd2);

        // ---- abort leaves the pointer alone ----
        pulse_reset();
        d = '0;
        d[0 +: DW]  = 32'h11;
        d[DW +: DW] = 32'h22;
        step(3'b001, d);
        step(3'b001, d);
        step(3'b001, d);
        step(3'b000, d);
        step(3'b000, d);
        step(3'b010, d);
        check_eq("t4_gnt", 64'(gnt_o[0]), 64'h2);
        step(3'b000, d);
        check_eq("t4_abort_gnt", 64'(gnt_o[0]), 64'h0);
        check_eq("t4_abort_ld", 64'(ld_o[0]), 64'h0);
        check_eq("t4_abort_busy", 64'(busy_o[0]), 64'h0);
        check_eq("t4_abort_ival", 64'(ival_o[0]), 64'h22);
        step(3'b011, d);
        check_eq("t4_regrant", 64'(gnt_o[0]), 64'h2);
        for (int i = 0; i < 5; i++) step(3'b011, d);

        // ---- data sampled only at grant ----
        pulse_reset();
        d = '0;
        d[2*DW +: DW] = 32'h1;
        step(3'b100, d);
        check_eq("t5_ival_g", 64'(ival_o[0]), 64'h1);
        d[2*DW +: DW] = 32'h2;
        step(3'b100, d);
        check_eq("t5_h1_ld", 64'(ld_o[1]), 64'h4);
        check_eq("t5_h1_ival", 64'(ival_o[1]), 64'h1);
        step(3'b100, d);
        check_eq("t5_ld", 64'(ld_o[0]), 64'h4);
        check_eq("t5_ival_ld", 64'(ival_o[0]), 64'h1);
        step(3'b000, d);
        step(3'b000, d);

        // ---- randomized traffic ----
        pulse_reset();
        r = '0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if (r[b]) begin
                    r[b] = ($urandom_range(0, 7) != 0);
                end else begin
                    r[b] = ($urandom_range(0, 2) == 0);
                end
            end
            d = {$urandom(), $urandom(), $urandom()};
            step(r, d);
            if ($urandom_range(0, 149) == 0) begin
                pulse_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
